// File: rtl/blk_cb63c4.sv
// AXI read-burst generator: splits (addr, beats) requests into 4 KB-safe AR bursts,
// credit-gated against the downstream read-data FIFO. Optional MAXI_RD_PERF_CNT_EN adds an AR counter.
module blk_cb63c4 #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned LEN_WIDTH  = 32,
  parameter int unsigned BUS_BYTES  = 64,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned MAX_OUTST  = 8,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic                  ar_valid,
  input  logic                  ar_ready,
  output logic [ADDR_WIDTH-1:0] ar_addr,
  output logic [7:0]            ar_len,
  input  logic                  r_last_hs,
  input  logic                  fifo_pop,
  output logic                  busy,
  output logic [31:0]           perf_ar_cnt
);

  localparam int unsigned OFF_W  = $clog2(BUS_BYTES);
  localparam int unsigned CRED_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OUT_W  = $clog2(MAX_OUTST + 1);
  localparam int unsigned CMP_W  = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [8:0]            beats_q, beats_d;
  logic [7:0]            ar_len_q, ar_len_d;
  logic [CRED_W-1:0]     credits_q, credits_d;
  logic [OUT_W-1:0]      outst_q, outst_d;

  logic [12:0]           page_room;
  logic [CMP_W-1:0]      cap;
  logic [CMP_W-1:0]      calc_beats;
  logic                  ar_hs;
  logic                  pop_ok;
  logic                  ret_ok;

  // Beats left before the next 4 KB page boundary.
  assign page_room = (13'd4096 - {1'b0, addr_q[11:0]}) >> OFF_W;

  always_comb begin
    cap = CMP_W'(MAX_BURST);
    if (CMP_W'(page_room) < cap) cap = CMP_W'(page_room);
    calc_beats = cap;
    if (CMP_W'(rem_q) < cap) calc_beats = CMP_W'(rem_q);
  end

  // Only credit returns and retirements can change these while waiting, and both can only
  // make the condition truer, so ar_valid cannot drop before ar_ready.
  assign ar_valid = (state_q == S_ISSUE) &&
                    (32'(credits_q) >= 32'(beats_q)) &&
                    (32'(outst_q) < MAX_OUTST);

  assign ar_hs     = ar_valid & ar_ready;
  assign pop_ok    = fifo_pop && (32'(credits_q) < FIFO_DEPTH);
  assign ret_ok    = r_last_hs && (outst_q != '0);
  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign ar_addr   = ar_addr_q;
  assign ar_len    = ar_len_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    beats_d   = beats_q;
    ar_addr_d = ar_addr_q;
    ar_len_d  = ar_len_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr & ~ADDR_WIDTH'(BUS_BYTES - 1);
          rem_d  = req_len;
          if (req_len != '0) state_d = S_CALC;
        end
      end
      S_CALC: begin
        beats_d   = 9'(calc_beats);
        ar_addr_d = addr_q;
        ar_len_d  = 8'(calc_beats - 1'b1);
        state_d   = S_ISSUE;
      end
      S_ISSUE: begin
        if (ar_hs) begin
          addr_d  = addr_q + (ADDR_WIDTH'(beats_q) << OFF_W);
          rem_d   = rem_q - LEN_WIDTH'(beats_q);
          state_d = (rem_d == '0) ? S_IDLE : S_CALC;
        end
      end
      default: state_d = S_IDLE;
    endcase
    credits_d = credits_q + CRED_W'(pop_ok) - (ar_hs ? CRED_W'(beats_q) : '0);
    outst_d   = outst_q + OUT_W'(ar_hs) - OUT_W'(ret_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      beats_q   <= '0;
      ar_addr_q <= '0;
      ar_len_q  <= '0;
      credits_q <= CRED_W'(FIFO_DEPTH);
      outst_q   <= '0;
    end else if (clk_en) begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      beats_q   <= beats_d;
      ar_addr_q <= ar_addr_d;
      ar_len_q  <= ar_len_d;
      credits_q <= credits_d;
      outst_q   <= outst_d;
    end
  end

`ifdef MAXI_RD_PERF_CNT_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= '0;
    end else if (clk_en && ar_hs) begin
      perf_q <= perf_q + 32'd1;
    end
  end
  assign perf_ar_cnt = perf_q;
`else
  assign perf_ar_cnt = '0;
`endif

  credit_no_overflow: assert property (@(posedge clk) disable iff (reset)
    (clk_en && fifo_pop) |-> (32'(credits_q) < FIFO_DEPTH));
  retire_needs_outst: assert property (@(posedge clk) disable iff (reset)
    (clk_en && r_last_hs) |-> (outst_q != '0));
  ar_stable: assert property (@(posedge clk) disable iff (reset)
    (ar_valid && !ar_ready) |=> (ar_valid && $stable(ar_addr) && $stable(ar_len)));

endmodule
